// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stop-vector constants, FSM encoding and default vectors
package pipe_ctrl_pkg;
  localparam int STOP_PC  = 0;
  localparam int STOP_IF  = 1;
  localparam int STOP_ID  = 2;
  localparam int STOP_EX  = 3;
  localparam int STOP_MEM = 4;
  localparam int STOP_WB  = 5;
  localparam logic [5:0] STOP_NONE      = 6'b000000;
  localparam logic [5:0] STOP_LOAD_USE  = 6'b000111;
  localparam logic [5:0] STOP_EX_BUSY   = 6'b001111;
  localparam logic [5:0] STOP_MEM_WAIT  = 6'b011111;
  localparam logic [5:0] STOP_ALL       = 6'b111111;
  localparam logic [31:0] BUS_ERR_VECTOR_DEF = 32'h0000_0040;
  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_FLUSH = 2'd1
  } ctrl_state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, exception inputs and control outputs of the pipeline controller
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_vector;
  logic        stat_clr;
  logic [5:0]  stop;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_abort;
  logic [31:0] stall_cycles;
  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_vector, stat_clr,
    input  stop, flush, new_pc, bus_abort, stall_cycles
  );
  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_vector, stat_clr,
    output stop, flush, new_pc, bus_abort, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_bus_watchdog.sv
// bus_watchdog: counts consecutive memory-stall cycles and fires on the limit
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stallreq_mem,
  output logic fire
);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  // fire on the TIMEOUT_CYC-th stall cycle; any gap or disable restarts the count
  always_comb begin
    fire = en && stallreq_mem && wd_cnt_q == 16'(TIMEOUT_CYC - 1);
    wd_cnt_d = (en && stallreq_mem) ? wd_cnt_q + 16'd1 : 16'd0;
  end
  // counter register
  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else wd_cnt_q <= wd_cnt_d;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stalls, sequences exception/timeout flushes, counts stall cycles
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC    = 255,
  parameter logic [31:0] BUS_ERR_VECTOR = BUS_ERR_VECTOR_DEF
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  ctrl_state_e state_q, state_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        run, fire, accept;
  assign run = state_q == CTRL_RUN;
  bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk          (clk),
    .rst          (rst),
    .en           (run),
    .stallreq_mem (bus.stallreq_mem),
    .fire         (fire)
  );
  // stall vector, flush sequencing, redirect target and saturating stall counter
  always_comb begin
    accept = run && bus.excp_valid && !bus.stallreq_mem;
    bus.stop = (rst || !run)          ? STOP_NONE :
               (fire || accept)       ? STOP_ALL :
               bus.stallreq_mem       ? STOP_MEM_WAIT :
               bus.stallreq_ex        ? STOP_EX_BUSY :
               bus.stallreq_id        ? STOP_LOAD_USE : STOP_NONE;
    bus.bus_abort = fire && !rst;
    state_d = (fire || accept) ? CTRL_FLUSH : CTRL_RUN;
    new_pc_d = fire ? BUS_ERR_VECTOR : accept ? bus.excp_vector : new_pc_q;
    stall_cycles_d = bus.stat_clr ? 32'd0 :
                     (bus.stop[STOP_PC] && stall_cycles_q != 32'hFFFF_FFFF) ? stall_cycles_q + 32'd1 :
                     stall_cycles_q;
  end
  // state, redirect and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CTRL_RUN;
      new_pc_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      new_pc_q       <= new_pc_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign bus.flush        = state_q == CTRL_FLUSH;
  assign bus.new_pc       = new_pc_q;
  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  localparam int TO = 4;
  localparam logic [31:0] BUS_ERR = 32'h0000_0040;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  pipe_ctrl_if bus();
  pipe_ctrl #(.TIMEOUT_CYC(TO), .BUS_ERR_VECTOR(BUS_ERR)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  bit m_flush;
  logic [31:0] m_pc, m_cnt;
  int m_run_len;
  logic [5:0] e_stop;
  bit e_abort, e_fire, e_acc;
  task automatic row(input bit [5:0] f, input logic [31:0] vec);
    {rst, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem, bus.excp_valid, bus.stat_clr} = f;
    bus.excp_vector = vec;
    #2;
    e_fire = 0;
    e_acc = 0;
    e_stop = 6'b000000;
    if (!rst && !m_flush) begin
      e_fire = bus.stallreq_mem && (m_run_len + 1 == TO);
      e_acc = bus.excp_valid && !bus.stallreq_mem;
      if (e_fire || e_acc) e_stop = 6'b111111;
      else if (bus.stallreq_mem) e_stop = 6'b011111;
      else if (bus.stallreq_ex) e_stop = 6'b001111;
      else if (bus.stallreq_id) e_stop = 6'b000111;
    end
    e_abort = e_fire;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_flush = 0;
      m_pc = 0;
      m_run_len = 0;
      m_cnt = 0;
    end else begin
      if (bus.stat_clr) m_cnt = 0;
      else if (e_stop[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (m_flush) begin
        m_flush = 0;
        m_run_len = 0;
      end else begin
        m_flush = e_fire || e_acc;
        if (e_fire) m_pc = BUS_ERR;
        else if (e_acc) m_pc = bus.excp_vector;
        m_run_len = bus.stallreq_mem ? m_run_len + 1 : 0;
      end
    end
    #1;
  endtask
  task automatic test_reset();
    row(6'b111111, 32'hDEAD_BEEF);
    n_tests++;
    if (bus.stop !== 6'b000000 || bus.bus_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first: stop=%b abort=%b, want 000000 0", bus.stop, bus.bus_abort);
    end
    tick();
    row(6'b111110, 32'hDEAD_BEEF);
    n_tests++;
    if (bus.stop !== 6'b000000 || bus.flush !== 1'b0 || bus.new_pc !== 32'd0 || bus.bus_abort !== 1'b0 || bus.stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: stop=%b flush=%b pc=%h abort=%b cnt=%h, want all zero", bus.stop, bus.flush, bus.new_pc, bus.bus_abort, bus.stall_cycles);
    end
    tick();
  endtask
  task automatic test_load_use();
    bit [5:0] seq[$] = '{6'b000001, 6'b010000, 6'b010000, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 0);
      n_tests++;
      if (bus.stop !== e_stop || bus.flush !== m_flush || bus.stall_cycles !== m_cnt) begin
        n_fail++;
        $display("FAIL load_use[%0d]: stop=%b flush=%b cnt=%0d, want %b %b %0d", i, bus.stop, bus.flush, bus.stall_cycles, e_stop, m_flush, m_cnt);
      end
      if (i == 3) begin
        n_tests++;
        if (bus.stall_cycles !== 32'd2) begin
          n_fail++;
          $display("FAIL load_use_count: got %0d, want 2", bus.stall_cycles);
        end
      end
      tick();
    end
  endtask
  task automatic test_priority();
    bit [5:0] seq[$] = '{6'b011100, 6'b011000, 6'b010000, 6'b000000};
    logic [5:0] want[$] = '{6'b011111, 6'b001111, 6'b000111, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 0);
      n_tests++;
      if (bus.stop !== want[i] || bus.bus_abort !== 1'b0) begin
        n_fail++;
        $display("FAIL priority[%0d]: stop=%b abort=%b, want %b 0", i, bus.stop, bus.bus_abort, want[i]);
      end
      tick();
    end
  endtask
  task automatic test_exception();
    bit [5:0] seq[$] = '{6'b000010, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 32'h8000_0180);
      n_tests++;
      if (bus.stop !== e_stop || bus.flush !== m_flush || bus.new_pc !== m_pc) begin
        n_fail++;
        $display("FAIL exception[%0d]: stop=%b flush=%b pc=%h, want %b %b %h", i, bus.stop, bus.flush, bus.new_pc, e_stop, m_flush, m_pc);
      end
      if (i == 1) begin
        n_tests++;
        if (bus.flush !== 1'b1 || bus.stop !== 6'b000000 || bus.new_pc !== 32'h8000_0180) begin
          n_fail++;
          $display("FAIL exception_flush: flush=%b stop=%b pc=%h, want 1 000000 80000180", bus.flush, bus.stop, bus.new_pc);
        end
      end
      tick();
    end
  endtask
  task automatic test_excp_during_mem();
    bit [5:0] seq[$] = '{6'b000110, 6'b000110, 6'b000110, 6'b000010, 6'b000000, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 32'h8000_0200);
      n_tests++;
      if (bus.stop !== e_stop || bus.flush !== m_flush || bus.new_pc !== m_pc || bus.bus_abort !== e_abort) begin
        n_fail++;
        $display("FAIL excp_mem[%0d]: stop=%b flush=%b pc=%h abort=%b, want %b %b %h %b", i, bus.stop, bus.flush, bus.new_pc, bus.bus_abort, e_stop, m_flush, m_pc, e_abort);
      end
      if (i < 3 || i == 4) begin
        n_tests++;
        if (bus.stop !== (i < 3 ? 6'b011111 : 6'b000000) || bus.flush !== (i == 4)) begin
          n_fail++;
          $display("FAIL excp_mem_lit[%0d]: stop=%b flush=%b", i, bus.stop, bus.flush);
        end
      end
      tick();
    end
  endtask
  task automatic test_timeout();
    bit [5:0] seq[$] = '{6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 0);
      n_tests++;
      if (bus.stop !== e_stop || bus.flush !== m_flush || bus.new_pc !== m_pc || bus.bus_abort !== e_abort) begin
        n_fail++;
        $display("FAIL timeout[%0d]: stop=%b flush=%b pc=%h abort=%b, want %b %b %h %b", i, bus.stop, bus.flush, bus.new_pc, bus.bus_abort, e_stop, m_flush, m_pc, e_abort);
      end
      n_tests++;
      if (bus.bus_abort !== (i == 3) || (i == 4 && (bus.flush !== 1'b1 || bus.new_pc !== BUS_ERR))) begin
        n_fail++;
        $display("FAIL timeout_lit[%0d]: abort=%b flush=%b pc=%h", i, bus.bus_abort, bus.flush, bus.new_pc);
      end
      tick();
    end
  endtask
  task automatic test_no_fire_on_drop();
    bit [5:0] seq[$] = '{6'b000100, 6'b000100, 6'b000100, 6'b000000, 6'b000100, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 0);
      n_tests++;
      if (bus.bus_abort !== 1'b0 || bus.flush !== 1'b0 || bus.stop !== e_stop) begin
        n_fail++;
        $display("FAIL no_fire[%0d]: abort=%b flush=%b stop=%b, want 0 0 %b", i, bus.bus_abort, bus.flush, bus.stop, e_stop);
      end
      tick();
    end
  endtask
  task automatic test_back_to_back();
    bit [5:0] seq[$] = '{6'b000010, 6'b000010, 6'b000010, 6'b000000, 6'b000000};
    bit want_flush[$] = '{0, 1, 0, 1, 0};
    foreach (seq[i]) begin
      row(seq[i], 32'h0000_1000 + 32'(i));
      n_tests++;
      if (bus.flush !== want_flush[i] || bus.stop !== e_stop || bus.new_pc !== m_pc) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: flush=%b stop=%b pc=%h, want %b %b %h", i, bus.flush, bus.stop, bus.new_pc, want_flush[i], e_stop, m_pc);
      end
      tick();
    end
    n_tests++;
    if (bus.new_pc !== 32'h0000_1002) begin
      n_fail++;
      $display("FAIL back_to_back_pc: got %h, want 00001002", bus.new_pc);
    end
  endtask
  task automatic test_reset_mid_flush();
    bit [5:0] seq[$] = '{6'b000010, 6'b100010, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 32'h8000_0180);
      n_tests++;
      if (bus.flush !== m_flush || bus.new_pc !== m_pc || bus.stop !== e_stop) begin
        n_fail++;
        $display("FAIL reset_flush[%0d]: flush=%b pc=%h stop=%b, want %b %h %b", i, bus.flush, bus.new_pc, bus.stop, m_flush, m_pc, e_stop);
      end
      if (i == 2) begin
        n_tests++;
        if (bus.flush !== 1'b0 || bus.new_pc !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_flush_lit: flush=%b pc=%h, want 0 00000000", bus.flush, bus.new_pc);
        end
      end
      tick();
    end
  endtask
  task automatic test_stat_clr();
    bit [5:0] seq[$] = '{6'b001000, 6'b001000, 6'b001001, 6'b000000};
    foreach (seq[i]) begin
      row(seq[i], 0);
      n_tests++;
      if (bus.stall_cycles !== m_cnt || bus.stop !== e_stop) begin
        n_fail++;
        $display("FAIL stat_clr[%0d]: cnt=%0d stop=%b, want %0d %b", i, bus.stall_cycles, bus.stop, m_cnt, e_stop);
      end
      if (i == 3) begin
        n_tests++;
        if (bus.stall_cycles !== 32'd0) begin
          n_fail++;
          $display("FAIL stat_clr_lit: cnt=%0d, want 0", bus.stall_cycles);
        end
      end
      tick();
    end
  endtask
  task automatic test_random();
    bit mem = 0;
    for (int i = 0; i < 3000; i++) begin
      bit [5:0] f;
      if ($urandom_range(0, 3) == 0) mem = !mem;
      f[5] = $urandom_range(0, 99) == 0;
      f[4] = $urandom_range(0, 3) == 0;
      f[3] = $urandom_range(0, 4) == 0;
      f[2] = mem;
      f[1] = $urandom_range(0, 5) == 0;
      f[0] = $urandom_range(0, 49) == 0;
      row(f, $urandom);
      n_tests++;
      if (bus.stop !== e_stop || bus.bus_abort !== e_abort || bus.flush !== m_flush || bus.new_pc !== m_pc || bus.stall_cycles !== m_cnt) begin
        n_fail++;
        $display("FAIL random[%0d]: stop=%b abort=%b flush=%b pc=%h cnt=%0d, want %b %b %b %h %0d", i, bus.stop, bus.bus_abort, bus.flush, bus.new_pc, bus.stall_cycles, e_stop, e_abort, m_flush, m_pc, m_cnt);
      end
      tick();
    end
    row(6'b000000, 0);
    tick();
    row(6'b000000, 0);
    tick();
  endtask
  initial begin
    m_flush = 0;
    m_pc = 0;
    m_cnt = 0;
    m_run_len = 0;
    test_reset();
    test_load_use();
    test_priority();
    test_exception();
    test_excp_during_mem();
    test_timeout();
    test_no_fire_on_drop();
    test_back_to_back();
    test_reset_mid_flush();
    test_stat_clr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
